// File: rtl/ofm_out_fsm.sv
// Output-side frame sequencer: pops one checksum control entry per frame,
// then streams that frame's data words from a FWFT FIFO onto an AXI-Stream
// master through a single output register, and counts completed frames.
module ofm_out_fsm #(
    parameter int C_CNT_WIDTH = 32
) (
    input  logic                   mm2s_clk,
    input  logic                   mm2s_reset,
    input  logic [63:0]            ctrl_fifo_rdata,
    input  logic                   ctrl_fifo_empty,
    output logic                   ctrl_fifo_rden,
    input  logic [72:0]            data_fifo_rdata,
    input  logic                   data_fifo_empty,
    output logic                   data_fifo_rden,
    output logic [63:0]            tx_axis_tdata,
    output logic [7:0]             tx_axis_tkeep,
    output logic                   tx_axis_tlast,
    output logic                   tx_axis_tvalid,
    input  logic                   tx_axis_tready,
    output logic [15:0]            tx_csum_begin,
    output logic [15:0]            tx_csum_insert,
    output logic [15:0]            tx_csum_init,
    output logic [1:0]             tx_csum_cntrl,
    output logic                   tx_csum_valid,
    output logic [C_CNT_WIDTH-1:0] tx_frame_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CTRL = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]             state_q;
    logic [1:0]             state_d;
    logic [63:0]            tdata_q;
    logic [7:0]             tkeep_q;
    logic                   tlast_q;
    logic                   tvalid_q;
    logic [15:0]            csum_begin_q;
    logic [15:0]            csum_insert_q;
    logic [15:0]            csum_init_q;
    logic [1:0]             csum_cntrl_q;
    logic                   csum_valid_q;
    logic [C_CNT_WIDTH-1:0] frame_cnt_q;
    logic [C_CNT_WIDTH-1:0] frame_cnt_d;

    logic ctrl_pop_s;
    logic data_pop_s;
    logic out_free_s;
    logic last_accept_s;
    logic unused_ctrl_bits_s;

    // Control entry bits above the checksum fields carry nothing for this block.
    assign unused_ctrl_bits_s = ^ctrl_fifo_rdata[63:50];

    // Next-state logic and FIFO pop decisions; pops are combinational so a
    // FWFT word can be consumed in the same cycle the output register frees.
    always_comb begin
        state_d       = state_q;
        ctrl_pop_s    = 1'b0;
        data_pop_s    = 1'b0;
        out_free_s    = (~tvalid_q) | tx_axis_tready;
        last_accept_s = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (!ctrl_fifo_empty) begin
                    state_d = S_CTRL;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CTRL: begin
                // Upstream only enqueues a control entry once its whole frame
                // is already in the data FIFO, so the pop is unconditional.
                ctrl_pop_s = 1'b1;
                state_d    = S_DATA;
            end
            S_DATA: begin
                if (!data_fifo_empty && out_free_s) begin
                    data_pop_s = 1'b1;
                    if (data_fifo_rdata[72]) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DATA;
                    end
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DONE: begin
                // The pending beat here is always the frame's last word.
                if (tvalid_q && tx_axis_tready && tlast_q) begin
                    last_accept_s = 1'b1;
                    frame_cnt_d   = frame_cnt_q + {{(C_CNT_WIDTH-1){1'b0}}, 1'b1};
                    state_d       = S_IDLE;
                end else begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM state and completed-frame counter.
    always_ff @(posedge mm2s_clk or posedge mm2s_reset) begin
        if (mm2s_reset) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= {C_CNT_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // AXI-Stream output register: load on pop, drop valid once accepted.
    always_ff @(posedge mm2s_clk or posedge mm2s_reset) begin
        if (mm2s_reset) begin
            tdata_q  <= 64'h0;
            tkeep_q  <= 8'h00;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else if (data_pop_s) begin
            tdata_q  <= data_fifo_rdata[63:0];
            tkeep_q  <= data_fifo_rdata[71:64];
            tlast_q  <= data_fifo_rdata[72];
            tvalid_q <= 1'b1;
        end else if (tx_axis_tready) begin
            tvalid_q <= 1'b0;
        end else begin
            tvalid_q <= tvalid_q;
        end
    end

    // Checksum sideband: captured at the control pop, held for the whole frame.
    always_ff @(posedge mm2s_clk or posedge mm2s_reset) begin
        if (mm2s_reset) begin
            csum_begin_q  <= 16'h0;
            csum_insert_q <= 16'h0;
            csum_init_q   <= 16'h0;
            csum_cntrl_q  <= 2'b00;
            csum_valid_q  <= 1'b0;
        end else if (ctrl_pop_s) begin
            csum_begin_q  <= ctrl_fifo_rdata[15:0];
            csum_insert_q <= ctrl_fifo_rdata[31:16];
            csum_init_q   <= ctrl_fifo_rdata[47:32];
            csum_cntrl_q  <= ctrl_fifo_rdata[49:48];
            csum_valid_q  <= 1'b1;
        end else if (last_accept_s) begin
            csum_valid_q  <= 1'b0;
        end else begin
            csum_valid_q  <= csum_valid_q;
        end
    end

    assign ctrl_fifo_rden = ctrl_pop_s;
    assign data_fifo_rden = data_pop_s;
    assign tx_axis_tdata  = tdata_q;
    assign tx_axis_tkeep  = tkeep_q;
    assign tx_axis_tlast  = tlast_q;
    assign tx_axis_tvalid = tvalid_q;
    assign tx_csum_begin  = csum_begin_q;
    assign tx_csum_insert = csum_insert_q;
    assign tx_csum_init   = csum_init_q;
    assign tx_csum_cntrl  = csum_cntrl_q;
    assign tx_csum_valid  = csum_valid_q;
    assign tx_frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_ofm_out_fsm.sv
// Bench for ofm_out_fsm: FIFO contents and expected beats are kept as queues;
// each cycle the DUT handshakes are compared against the protocol rules.
module tb_ofm_out_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   ctrl_rdata;
    logic          ctrl_empty;
    logic          ctrl_rden;
    logic [72:0]   data_rdata;
    logic          data_empty;
    logic          data_rden;
    logic [63:0]   tdata;
    logic [7:0]    tkeep;
    logic          tlast;
    logic          tvalid;
    logic          tready;
    logic [15:0]   csum_begin;
    logic [15:0]   csum_insert;
    logic [15:0]   csum_init;
    logic [1:0]    csum_cntrl;
    logic          csum_valid;
    logic [CW-1:0] frame_cnt;

    always #5 clk = ~clk;

    ofm_out_fsm #(.C_CNT_WIDTH(CW)) dut (
        .mm2s_clk(clk), .mm2s_reset(rst),
        .ctrl_fifo_rdata(ctrl_rdata), .ctrl_fifo_empty(ctrl_empty), .ctrl_fifo_rden(ctrl_rden),
        .data_fifo_rdata(data_rdata), .data_fifo_empty(data_empty), .data_fifo_rden(data_rden),
        .tx_axis_tdata(tdata), .tx_axis_tkeep(tkeep), .tx_axis_tlast(tlast),
        .tx_axis_tvalid(tvalid), .tx_axis_tready(tready),
        .tx_csum_begin(csum_begin), .tx_csum_insert(csum_insert), .tx_csum_init(csum_init),
        .tx_csum_cntrl(csum_cntrl), .tx_csum_valid(csum_valid), .tx_frame_cnt(frame_cnt)
    );

    // Reference model state
    logic [63:0] cq[$];
    logic [72:0] dq[$];
    logic [72:0] exp_beats[$];
    logic [63:0] cur_ctrl;
    logic [72:0] held_beat;
    bit          busy, in_frame, held, idle_arm, force_empty, rand_empty, obs_tvalid;
    int          checks, errors, frames_done, pops_in_frame, beats_in_frame, mode, tr_cnt;

    task automatic chk(input string tag, input logic [72:0] obs, input logic [72:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        ctrl_rdata = (cq.size() > 0) ? cq[0] : 64'h0;
        ctrl_empty = (cq.size() == 0);
        data_rdata = (dq.size() > 0) ? dq[0] : 73'h0;
        data_empty = force_empty || rand_empty || (dq.size() == 0);
    endtask

    task automatic push_frame(input int n, input logic [7:0] klast, input logic [49:0] c);
        logic [72:0] w;
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            w = {(i == n - 1), ((i == n - 1) ? klast : 8'hFF), $urandom(), $urandom()};
            dq.push_back(w);
            exp_beats.push_back(w);
        end
        r = $urandom();
        cq.push_back({r[13:0], c});
        drive();
    endtask

    task automatic cycle();
        logic [72:0] beat, w;
        logic exp_c, exp_d, c_pop, d_pop, last_acc, arm_n;
        last_acc = 1'b0;
        @(negedge clk);
        beat       = {tlast, tkeep, tdata};
        obs_tvalid = tvalid;
        exp_c = idle_arm && !busy && !rst;
        chk("ctrl_rden", ctrl_rden, exp_c);
        exp_d = in_frame && !data_empty && (!tvalid || tready) && !rst;
        chk("data_rden", data_rden, exp_d);
        chk("csum_valid", csum_valid, busy);
        if (busy) chk("csum_fields", {csum_cntrl, csum_init, csum_insert, csum_begin}, cur_ctrl[49:0]);
        if (held) begin
            chk("hold_valid", tvalid, 1'b1);
            chk("hold_beat", beat, held_beat);
        end
        if (tvalid && tready) begin
            if (exp_beats.size() > 0) chk("beat", beat, exp_beats.pop_front());
            else chk("beat_extra", exp_beats.size(), 1);
            beats_in_frame++;
            if (beat[72]) last_acc = 1'b1;
        end
        held      = tvalid && !tready;
        held_beat = beat;
        c_pop     = ctrl_rden;
        d_pop     = data_rden;
        arm_n     = !busy && !ctrl_rden && !ctrl_empty && !rst;
        @(posedge clk);
        #1;
        if (c_pop) begin
            cur_ctrl = cq.pop_front();
            busy = 1'b1; in_frame = 1'b1; pops_in_frame = 0; beats_in_frame = 0;
        end
        if (d_pop) begin
            w = dq.pop_front();
            pops_in_frame++;
            if (w[72]) in_frame = 1'b0;
            chk("latency_valid", tvalid, 1'b1);
            chk("latency_beat", {tlast, tkeep, tdata}, w);
        end
        if (last_acc) begin
            busy = 1'b0;
            frames_done++;
            chk("frame_cnt", frame_cnt, frames_done % 16);
            chk("csum_clear", csum_valid, 1'b0);
        end
        idle_arm = arm_n;
        tr_cnt++;
        case (mode)
            1:       tready = ((tr_cnt % 3) == 0);
            2:       tready = ($urandom_range(0, 3) != 0);
            default: tready = 1'b1;
        endcase
        rand_empty = (mode == 2) && ($urandom_range(0, 7) == 0);
        drive();
    endtask

    task automatic drain(input int budget);
        for (int k = 0; k < budget && (exp_beats.size() > 0 || cq.size() > 0 || busy); k++) cycle();
        chk("drain", exp_beats.size() + cq.size(), 0);
    endtask

    initial begin
        checks = 0; errors = 0; frames_done = 0; pops_in_frame = 0; beats_in_frame = 0;
        busy = 0; in_frame = 0; held = 0; idle_arm = 0; force_empty = 0; rand_empty = 0;
        mode = 0; tr_cnt = 0; cur_ctrl = 64'h0; held_beat = 73'h0;
        rst = 1'b1; tready = 1'b1;
        drive();

        // Reset values
        #12;
        chk("rst_tvalid", tvalid, 1'b0);
        chk("rst_tlast", tlast, 1'b0);
        chk("rst_rden", {ctrl_rden, data_rden}, 2'b00);
        chk("rst_csum", {csum_valid, csum_cntrl, csum_init, csum_insert, csum_begin}, 51'h0);
        chk("rst_cnt", frame_cnt, 4'h0);
        chk("rst_beat", {tkeep, tdata}, 72'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single frame, tready high
        push_frame(3, 8'h0F, {2'b01, 16'h1234, 16'h0028, 16'h000E});
        drain(100);
        chk("single_cnt", frame_cnt, 4'd1);
        chk("single_beats", beats_in_frame, 3);

        // tready toggling 1,0,0
        mode = 1;
        push_frame(3, 8'h0F, {2'b01, 16'h1234, 16'h0028, 16'h000E});
        drain(100);
        chk("toggle_beats", beats_in_frame, 3);
        mode = 0; tready = 1'b1;

        // Data FIFO empty gap after word 1
        push_frame(3, 8'h0F, {2'b10, 16'hBEEF, 16'h0030, 16'h0010});
        for (int k = 0; k < 20 && pops_in_frame < 1; k++) cycle();
        force_empty = 1'b1;
        drive();
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (i >= 1) chk("gap_tvalid", obs_tvalid, 1'b0);
        end
        force_empty = 1'b0;
        drive();
        drain(100);
        chk("gap_beats", beats_in_frame, 3);

        // Two back-to-back frames
        push_frame(2, 8'hFF, {2'b11, 16'h1111, 16'h0022, 16'h0033});
        push_frame(1, 8'h03, {2'b00, 16'h4444, 16'h0055, 16'h0066});
        drain(100);
        chk("b2b_cnt", frame_cnt, 4'd5);

        // Reset during beat 2 of 4
        push_frame(4, 8'h01, {2'b01, 16'hAAAA, 16'h00BB, 16'h00CC});
        for (int k = 0; k < 20 && !(busy && beats_in_frame == 1); k++) cycle();
        rst = 1'b1;
        #1;
        chk("abort_tvalid", tvalid, 1'b0);
        chk("abort_cnt", frame_cnt, 4'h0);
        chk("abort_csum_valid", csum_valid, 1'b0);
        dq.delete(); cq.delete(); exp_beats.delete();
        busy = 0; in_frame = 0; held = 0; idle_arm = 0; frames_done = 0;
        drive();
        for (int i = 0; i < 3; i++) cycle();
        rst = 1'b0;
        push_frame(2, 8'h07, {2'b10, 16'h5A5A, 16'h0012, 16'h0034});
        drain(100);
        chk("fresh_cnt", frame_cnt, 4'd1);

        // Counter wrap
        for (int f = 0; f < 15; f++) push_frame(1, 8'hFF, {2'b01, 16'(f), 16'h0002, 16'h0003});
        drain(400);
        chk("wrap_cnt", frame_cnt, 4'd0);
        push_frame(1, 8'h0F, {2'b01, 16'h0001, 16'h0002, 16'h0003});
        drain(100);
        chk("post_wrap_cnt", frame_cnt, 4'd1);

        // Randomized traffic
        mode = 2;
        for (int f = 0; f < 25; f++) begin
            push_frame($urandom_range(1, 5), 8'($urandom()), 50'({$urandom(), $urandom()}));
            for (int k = 0; k < $urandom_range(0, 6); k++) cycle();
        end
        drain(2000);
        mode = 0; tready = 1'b1; rand_empty = 1'b0;
        drive();
        chk("rand_cnt", frame_cnt, frames_done % 16);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
